// File: rtl/d_stim_pkg.sv
// Shared types and constants for the serial stimulus transmitter.
package d_stim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // A length of zero, or one larger than the pattern register, means "send everything".
  function automatic int len_norm(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/d_stim_bit_timer.sv
// Per-bit hold counter: counts 0..hold and strobes bit_end on the last cycle of each bit.
module d_stim_bit_timer #(
  parameter int HOLD_W = 4
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              clear,
  input  logic [HOLD_W-1:0] hold,
  output logic              bit_end
);

  logic [HOLD_W-1:0] cnt;

  assign bit_end = !clear && (cnt == hold);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/d_stim_gen.sv
// Serial stimulus transmitter: shifts a captured pattern out MSB-first on D, each bit held Hold+1 cycles.
// Optional feature macro D_STIM_LFSR_EN adds a Mode input selecting a 16-bit LFSR bit source.
//
// state | meaning
// IDLE  | D=0, Start_ready=1, waiting for a Start_valid handshake
// RUN   | shifting the shadowed pattern (or LFSR) out on D
module d_stim_gen
  import d_stim_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HOLD_W = 4,
  parameter int LEN_W  = $clog2(WIDTH + 1)
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic [WIDTH-1:0]  Pat,
  input  logic [LEN_W-1:0]  Len,
  input  logic [HOLD_W-1:0] Hold,
  input  logic              Repeat,
`ifdef D_STIM_LFSR_EN
  input  logic              Mode,
`endif
  input  logic              Start_valid,
  output logic              Start_ready,
  input  logic              Stop,
  output logic              D,
  output logic              Busy,
  output logic              Done
);

  localparam int IW = $clog2(WIDTH);

  state_t            state;
  logic [WIDTH-1:0]  sh_pat;
  logic [IW-1:0]     sh_last;
  logic [HOLD_W-1:0] sh_hold;
  logic              sh_rep;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     in_last;
  logic              d_q, busy_q, ready_q, done_q;
  logic              bit_end, timer_clear;
  logic              first_bit, step_bit, wrap_bit;
  logic              handshake;

`ifdef D_STIM_LFSR_EN
  logic              sh_mode;
  logic [15:0]       lfsr, lfsr_next, seed;
`endif

  assign handshake   = Start_valid && ready_q && !Stop;
  assign timer_clear = (state != RUN);

  always_comb begin
    in_last   = IW'(len_norm(int'(Len), WIDTH) - 1);
    first_bit = Pat[in_last];
    step_bit  = sh_pat[idx - IW'(1)];
    wrap_bit  = sh_pat[sh_last];
`ifdef D_STIM_LFSR_EN
    seed      = (16'(Pat) == 16'h0000) ? LFSR_DEFAULT_SEED : 16'(Pat);
    lfsr_next = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    if (Mode) first_bit = seed[0];
    if (sh_mode) begin
      step_bit = lfsr_next[0];
      wrap_bit = lfsr_next[0];
    end
`endif
  end

  d_stim_bit_timer #(.HOLD_W(HOLD_W)) u_bit_timer (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .clear   (timer_clear),
    .hold    (sh_hold),
    .bit_end (bit_end)
  );

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      sh_pat  <= '0;
      sh_last <= '0;
      sh_hold <= '0;
      sh_rep  <= 1'b0;
      idx     <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef D_STIM_LFSR_EN
      sh_mode <= 1'b0;
      lfsr    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            sh_pat  <= Pat;
            sh_last <= in_last;
            sh_hold <= Hold;
            sh_rep  <= Repeat;
            idx     <= in_last;
            d_q     <= first_bit;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= RUN;
`ifdef D_STIM_LFSR_EN
            sh_mode <= Mode;
            lfsr    <= seed;
`endif
          end
        end
        RUN: begin
          if (Stop) begin
            state   <= IDLE;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (bit_end) begin
            if (idx != '0) begin
              idx <= idx - IW'(1);
              d_q <= step_bit;
`ifdef D_STIM_LFSR_EN
              lfsr <= lfsr_next;
`endif
            end else if (sh_rep) begin
              // Wrap straight to the first bit so repeats have no gap cycle.
              idx <= sh_last;
              d_q <= wrap_bit;
`ifdef D_STIM_LFSR_EN
              lfsr <= lfsr_next;
`endif
            end else begin
              state   <= IDLE;
              d_q     <= 1'b0;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign D           = d_q;
  assign Busy        = busy_q;
  assign Start_ready = ready_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_d_stim_gen.sv
// Directed-vector bench for d_stim_gen; LFSR vectors only when D_STIM_LFSR_EN is defined.
module tb_d_stim_gen;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic [15:0] Pat;
  logic [4:0]  Len;
  logic [3:0]  Hold;
  logic        Repeat;
  logic        Start_valid;
  logic        Start_ready;
  logic        Stop;
  logic        D, Busy, Done;
`ifdef D_STIM_LFSR_EN
  logic        Mode;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  d_stim_gen #(.WIDTH(16), .HOLD_W(4)) dut (
    .Clk         (Clk),
    .Resetn      (Resetn),
    .Pat         (Pat),
    .Len         (Len),
    .Hold        (Hold),
    .Repeat      (Repeat),
`ifdef D_STIM_LFSR_EN
    .Mode        (Mode),
`endif
    .Start_valid (Start_valid),
    .Start_ready (Start_ready),
    .Stop        (Stop),
    .D           (D),
    .Busy        (Busy),
    .Done        (Done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake on the next edge, then scramble the inputs to prove they are shadowed.
  task automatic start_run(input logic [15:0] p, input logic [4:0] l, input logic [3:0] h, input logic r);
    @(negedge Clk);
    Pat = p; Len = l; Hold = h; Repeat = r; Start_valid = 1'b1;
    @(negedge Clk);
    Start_valid = 1'b0;
    Pat = ~p; Len = 5'd1; Hold = ~h; Repeat = ~r;
  endtask

  // Called at the first negedge after the handshake; checks n bits (MSB of the n-bit field first).
  task automatic expect_bits(input string tag, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s d%0d", tag, i), {31'd0, D}, {31'd0, bits[n-1-i]});
      check_val($sformatf("%s busy%0d", tag, i), {31'd0, Busy}, 32'd1);
      check_val($sformatf("%s nodone%0d", tag, i), {31'd0, Done}, 32'd0);
      @(negedge Clk);
    end
  endtask

  task automatic expect_done(input string tag);
    check_val({tag, " done"}, {31'd0, Done}, 32'd1);
    check_val({tag, " done busy"}, {31'd0, Busy}, 32'd0);
    check_val({tag, " done d"}, {31'd0, D}, 32'd0);
    check_val({tag, " done ready"}, {31'd0, Start_ready}, 32'd1);
    @(negedge Clk);
    check_val({tag, " done pulse"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    logic [15:0] l;
    logic [63:0] e;
    Resetn = 1'b0; Pat = '0; Len = '0; Hold = '0; Repeat = 1'b0;
    Start_valid = 1'b0; Stop = 1'b0;
`ifdef D_STIM_LFSR_EN
    Mode = 1'b0;
`endif
    #12;
    check_val("rst d", {31'd0, D}, 32'd0);
    check_val("rst busy", {31'd0, Busy}, 32'd0);
    check_val("rst ready", {31'd0, Start_ready}, 32'd1);
    check_val("rst done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Resetn = 1'b1;

    // Full 16-bit pattern, one cycle per bit
    start_run(16'hA5C3, 5'd16, 4'd0, 1'b0);
    check_val("a5c3 ready", {31'd0, Start_ready}, 32'd0);
    expect_bits("a5c3", 64'hA5C3, 16);
    expect_done("a5c3");

    // 4 bits, three cycles each; done lands on cycle 13
    start_run(16'h000D, 5'd4, 4'd2, 1'b0);
    expect_bits("hold2", 64'b111111000111, 12);
    expect_done("hold2");

    // Repeat with no gap, stopped after cycle 8
    start_run(16'h0005, 5'd3, 4'd1, 1'b1);
    expect_bits("rep", 64'b11001111, 8);
    Stop = 1'b1;
    @(negedge Clk);
    Stop = 1'b0;
    check_val("stop d", {31'd0, D}, 32'd0);
    check_val("stop busy", {31'd0, Busy}, 32'd0);
    check_val("stop ready", {31'd0, Start_ready}, 32'd1);
    check_val("stop done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    check_val("stop done2", {31'd0, Done}, 32'd0);
    check_val("stop busy2", {31'd0, Busy}, 32'd0);

    // Stop beats Start_valid in IDLE
    Pat = 16'hFFFF; Len = 5'd4; Hold = 4'd0; Repeat = 1'b0;
    Stop = 1'b1; Start_valid = 1'b1;
    @(negedge Clk);
    check_val("stopwin busy", {31'd0, Busy}, 32'd0);
    check_val("stopwin ready", {31'd0, Start_ready}, 32'd1);
    check_val("stopwin d", {31'd0, D}, 32'd0);
    @(negedge Clk);
    check_val("stopwin busy2", {31'd0, Busy}, 32'd0);
    Stop = 1'b0; Start_valid = 1'b0;

    // Back-to-back: Start_valid held through the Done cycle, new pattern captured there
    @(negedge Clk);
    Pat = 16'h0002; Len = 5'd2; Hold = 4'd0; Repeat = 1'b0; Start_valid = 1'b1;
    @(negedge Clk);
    check_val("b2b c1 d", {31'd0, D}, 32'd1);
    @(negedge Clk);
    check_val("b2b c2 d", {31'd0, D}, 32'd0);
    @(negedge Clk);
    check_val("b2b c3 done", {31'd0, Done}, 32'd1);
    check_val("b2b c3 d", {31'd0, D}, 32'd0);
    check_val("b2b c3 busy", {31'd0, Busy}, 32'd0);
    Pat = 16'h0001;
    @(negedge Clk);
    Start_valid = 1'b0;
    check_val("b2b c4 busy", {31'd0, Busy}, 32'd1);
    check_val("b2b c4 d", {31'd0, D}, 32'd0);
    check_val("b2b c4 done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    check_val("b2b c5 d", {31'd0, D}, 32'd1);
    @(negedge Clk);
    check_val("b2b c6 done", {31'd0, Done}, 32'd1);
    @(negedge Clk);

    // Len=0 means full width
    start_run(16'h8001, 5'd0, 4'd0, 1'b0);
    expect_bits("len0", 64'h8001, 16);
    expect_done("len0");

    // Len beyond WIDTH also means full width
    start_run(16'h4C31, 5'd20, 4'd0, 1'b0);
    expect_bits("len20", 64'h4C31, 16);
    expect_done("len20");

    // Asynchronous reset in the middle of a run
    start_run(16'hFFFF, 5'd16, 4'd3, 1'b1);
    repeat (3) @(negedge Clk);
    check_val("midrst pre busy", {31'd0, Busy}, 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check_val("midrst d", {31'd0, D}, 32'd0);
    check_val("midrst busy", {31'd0, Busy}, 32'd0);
    check_val("midrst ready", {31'd0, Start_ready}, 32'd1);
    check_val("midrst done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Resetn = 1'b1;
    @(negedge Clk);
    check_val("midrst after busy", {31'd0, Busy}, 32'd0);
    check_val("midrst after done", {31'd0, Done}, 32'd0);
    check_val("midrst after d", {31'd0, D}, 32'd0);

`ifdef D_STIM_LFSR_EN
    // LFSR mode, zero seed falls back to 16'hACE1
    l = 16'hACE1;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      e[15-i] = l[0];
      l = {l[14:0], ^(l & 16'hB400)};
    end
    Mode = 1'b1;
    start_run(16'h0000, 5'd0, 4'd0, 1'b0);
    Mode = 1'b0;
    expect_bits("lfsr", e, 16);
    expect_done("lfsr");
`else
    l = '0;
    e = '0;
`endif

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
